// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline register with a 2-entry skid buffer and a flush bubble
// Ports:
//   clk, rst_n (async, active-low), flush (sync squash)
//   in_valid/in_ready/in_data    upstream handshake; in_ready is a flop output
//   out_valid/out_ready/out_data downstream handshake; out_data is the bubble when idle
//   stall_cnt, flush_cnt         saturating counters, present only when PIPE_PERF_EN is defined
// Optional feature macro: PIPE_PERF_EN
module pipe_stage_skid #(
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_FIELDS = 3,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_FIELDS*DATA_WIDTH-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_FIELDS*DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]             stall_cnt,
  output logic [CNT_WIDTH-1:0]             flush_cnt
);
  localparam int W = NUM_FIELDS * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTR);
  localparam logic [W-1:0] BUBBLE = W'(NOP);
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         acc, dep;
  assign in_ready = !skid_valid;
  assign acc = in_valid && in_ready;
  assign dep = out_valid && out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= BUBBLE;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= BUBBLE;
      skid_data  <= '0;
    end else if (skid_valid) begin
      if (out_ready) begin
        out_data   <= skid_data;
        skid_valid <= 1'b0;
        skid_data  <= '0;
      end
    end else if (out_valid) begin
      if (acc && dep) out_data <= in_data;
      else if (acc) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end else if (dep) begin
        out_valid <= 1'b0;
        out_data  <= BUBBLE;
      end
    end else if (acc) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end
  end
`ifdef PIPE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && (out_valid || skid_valid) && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and random checks of pipe_stage_skid against a queue model
module tb_pipe_stage_skid;
  localparam int DW = 32;
  localparam int NF = 3;
  localparam int W  = DW * NF;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [W-1:0] BUBBLE = W'(32'h00000013);
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int errors = 0;
  int checks = 0;
  logic [W-1:0] q[$];
  int sc = 0;
  int fc = 0;
  pipe_stage_skid #(.DATA_WIDTH(DW), .NUM_FIELDS(NF), .NOP_INSTR(32'h00000013), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic check_all();
    chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
    chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
    chk("out_data", 128'(out_data), 128'(q.size() > 0 ? q[0] : BUBBLE));
`ifdef PIPE_PERF_EN
    chk("stall_cnt", 128'(stall_cnt), 128'(sc));
    chk("flush_cnt", 128'(flush_cnt), 128'(fc));
`else
    chk("stall_cnt", 128'(stall_cnt), 128'(0));
    chk("flush_cnt", 128'(flush_cnt), 128'(0));
`endif
  endtask
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    bit a, dp;
    in_valid = v; in_data = d; out_ready = r; flush = f;
    a  = v && q.size() < 2;
    dp = q.size() > 0 && r;
    if (q.size() > 0 && !r && sc < CMAX) sc++;
    if (f) begin
      if (q.size() > 0 && fc < CMAX) fc++;
      q.delete();
    end else begin
      if (dp) void'(q.pop_front());
      if (a) q.push_back(d);
    end
    @(negedge clk);
    check_all();
  endtask
  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom};
  endfunction
  initial begin
    logic [W-1:0] a, b, c;
    a = rnd(); b = rnd(); c = rnd();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
    cyc(1, a, 1, 0); cyc(1, b, 1, 0); cyc(1, c, 1, 0);
    cyc(0, '0, 1, 0); cyc(0, '0, 1, 0);
    cyc(1, a, 0, 0); cyc(1, b, 0, 0); cyc(1, c, 0, 0); cyc(0, '0, 0, 0);
    cyc(1, c, 1, 0); cyc(0, '0, 1, 0); cyc(0, '0, 1, 0);
    cyc(1, a, 0, 0); cyc(1, b, 0, 0); cyc(0, '0, 0, 1);
    cyc(1, c, 1, 1); cyc(0, '0, 1, 0);
    cyc(1, a, 0, 0); cyc(1, b, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    q.delete(); sc = 0; fc = 0;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
    cyc(1, a, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, '0, 0, 0);
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(3, 0) != 0, rnd(), $urandom_range(2, 0) != 0, $urandom_range(15, 0) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
